// File: rtl/core_pkg.sv
// Shared RV32I core definitions: decoded control bundle, ALU opcodes and
// operand source-select encodings used by the ID/EX stage and the ALU.
package core_pkg;

   localparam int XLEN_C  = 32;
   localparam int REG_AW  = 5;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;
   localparam logic [3:0] ALU_PASS = 4'd10;

   localparam logic SRC_A_RS1 = 1'b0;
   localparam logic SRC_A_PC  = 1'b1;
   localparam logic SRC_B_RS2 = 1'b0;
   localparam logic SRC_B_IMM = 1'b1;

   typedef struct packed {
      logic [3:0] alu_op;
      logic       src_a_sel;
      logic       src_b_sel;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       uses_rs1;
      logic       uses_rs2;
   } id_ctrl_t;

   // ALU_ADD is all-zero, so the bubble is simply an all-zero control word.
   localparam id_ctrl_t CTRL_BUBBLE = '{alu_op: ALU_ADD, default: 1'b0};

   // A writeback port hits a source only when enabled, index-matched and not x0.
   function automatic logic wb_hit(input logic               wen,
                                   input logic [REG_AW-1:0] rd,
                                   input logic [REG_AW-1:0] rs);
      return wen && (rd == rs) && (rs != '0);
   endfunction

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// Per-source forwarding mux: picks EX/MEM, then MEM/WB, then the held register value.
module fwd_unit
   import core_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [4:0]      rs_addr_i,
   input  logic [XLEN-1:0] rs_data_i,
   input  logic            exmem_wen_i,
   input  logic [4:0]      exmem_rd_i,
   input  logic [XLEN-1:0] exmem_data_i,
   input  logic            memwb_wen_i,
   input  logic [4:0]      memwb_rd_i,
   input  logic [XLEN-1:0] memwb_data_i,
   output logic [XLEN-1:0] fwd_data_o
);

   logic w_exmem_hit;
   logic w_memwb_hit;

   assign w_exmem_hit = wb_hit(exmem_wen_i, exmem_rd_i, rs_addr_i);
   assign w_memwb_hit = wb_hit(memwb_wen_i, memwb_rd_i, rs_addr_i);

   // The younger producer (EX/MEM) always shadows the older one.
   always_comb begin
      fwd_data_o = rs_data_i;
      if (w_exmem_hit)
         fwd_data_o = exmem_data_i;
      else if (w_memwb_hit)
         fwd_data_o = memwb_data_i;
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, ALU source selection and
// load-use hazard detection for the 5-stage RV32I core.
module id_ex_stage
   import core_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            stall_i,
   input  logic            flush_i,
   input  logic            valid_i,
   input  id_ctrl_t        ctrl_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [4:0]      rs1_addr_i,
   input  logic [4:0]      rs2_addr_i,
   input  logic [4:0]      rd_addr_i,
   input  logic [XLEN-1:0] rs1_data_i,
   input  logic [XLEN-1:0] rs2_data_i,
   input  logic [XLEN-1:0] imm_i,
   input  logic            exmem_wen_i,
   input  logic [4:0]      exmem_rd_i,
   input  logic [XLEN-1:0] exmem_data_i,
   input  logic            memwb_wen_i,
   input  logic [4:0]      memwb_rd_i,
   input  logic [XLEN-1:0] memwb_data_i,
   output logic [XLEN-1:0] operand_a_o,
   output logic [XLEN-1:0] operand_b_o,
   output logic [3:0]      alu_op_o,
   output logic            valid_o,
   output id_ctrl_t        ctrl_o,
   output logic [XLEN-1:0] pc_o,
   output logic [4:0]      rd_addr_o,
   output logic [XLEN-1:0] store_data_o,
   output logic            load_use_o
);

   logic            r_vld_p1;
   id_ctrl_t        r_ctrl_p1;
   logic [XLEN-1:0] r_pc_p1;
   logic [4:0]      r_rd_p1;
   logic [4:0]      r_rs1_p1;
   logic [4:0]      r_rs2_p1;
   logic [XLEN-1:0] r_rs1_data_p1;
   logic [XLEN-1:0] r_rs2_data_p1;
   logic [XLEN-1:0] r_imm_p1;

   logic [XLEN-1:0] w_fwd_rs1;
   logic [XLEN-1:0] w_fwd_rs2;
   logic            w_rs1_dep;
   logic            w_rs2_dep;

   // ---- ID -> EX boundary ----
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_vld_p1      <= 1'b0;
         r_ctrl_p1     <= CTRL_BUBBLE;
         r_pc_p1       <= '0;
         r_rd_p1       <= '0;
         r_rs1_p1      <= '0;
         r_rs2_p1      <= '0;
         r_rs1_data_p1 <= '0;
         r_rs2_data_p1 <= '0;
         r_imm_p1      <= '0;
      end else if (flush_i) begin
         r_vld_p1      <= 1'b0;
         r_ctrl_p1     <= CTRL_BUBBLE;
         r_pc_p1       <= '0;
         r_rd_p1       <= '0;
         r_rs1_p1      <= '0;
         r_rs2_p1      <= '0;
         r_rs1_data_p1 <= '0;
         r_rs2_data_p1 <= '0;
         r_imm_p1      <= '0;
      end else if (stall_i) begin
         // Absorb producers that retire while we wait, so they are not lost.
         r_rs1_data_p1 <= w_fwd_rs1;
         r_rs2_data_p1 <= w_fwd_rs2;
      end else begin
         r_vld_p1      <= valid_i;
         r_ctrl_p1     <= ctrl_i;
         r_pc_p1       <= pc_i;
         r_rd_p1       <= rd_addr_i;
         r_rs1_p1      <= rs1_addr_i;
         r_rs2_p1      <= rs2_addr_i;
         r_rs1_data_p1 <= rs1_data_i;
         r_rs2_data_p1 <= rs2_data_i;
         r_imm_p1      <= imm_i;
      end
   end

   fwd_unit #(.XLEN(XLEN)) u_fwd_rs1 (
      .rs_addr_i    (r_rs1_p1),
      .rs_data_i    (r_rs1_data_p1),
      .exmem_wen_i  (exmem_wen_i),
      .exmem_rd_i   (exmem_rd_i),
      .exmem_data_i (exmem_data_i),
      .memwb_wen_i  (memwb_wen_i),
      .memwb_rd_i   (memwb_rd_i),
      .memwb_data_i (memwb_data_i),
      .fwd_data_o   (w_fwd_rs1)
   );

   fwd_unit #(.XLEN(XLEN)) u_fwd_rs2 (
      .rs_addr_i    (r_rs2_p1),
      .rs_data_i    (r_rs2_data_p1),
      .exmem_wen_i  (exmem_wen_i),
      .exmem_rd_i   (exmem_rd_i),
      .exmem_data_i (exmem_data_i),
      .memwb_wen_i  (memwb_wen_i),
      .memwb_rd_i   (memwb_rd_i),
      .memwb_data_i (memwb_data_i),
      .fwd_data_o   (w_fwd_rs2)
   );

   assign operand_a_o  = (r_ctrl_p1.src_a_sel == SRC_A_PC)  ? r_pc_p1  : w_fwd_rs1;
   assign operand_b_o  = (r_ctrl_p1.src_b_sel == SRC_B_IMM) ? r_imm_p1 : w_fwd_rs2;
   assign store_data_o = w_fwd_rs2;
   assign alu_op_o     = r_ctrl_p1.alu_op;
   assign valid_o      = r_vld_p1;
   assign ctrl_o       = r_ctrl_p1;
   assign pc_o         = r_pc_p1;
   assign rd_addr_o    = r_rd_p1;

   // A load in EX cannot forward its data in time to the instruction in decode.
   assign w_rs1_dep  = valid_i && ctrl_i.uses_rs1 && (rs1_addr_i == r_rd_p1);
   assign w_rs2_dep  = valid_i && ctrl_i.uses_rs2 && (rs2_addr_i == r_rd_p1);
   assign load_use_o = r_vld_p1 && r_ctrl_p1.mem_read && (r_rd_p1 != 5'd0)
                       && (w_rs1_dep || w_rs2_dep);

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage
ID/EX pipeline register and execute-stage operand front end of the 5-stage RV32I core. Captures the decoded instruction each cycle, resolves EX/MEM and MEM/WB forwarding on the held register operands, selects ALU sources, and drives the ALU operand and opcode inputs. Also flags load-use hazards back to decode and honours stall/flush from the hazard unit.
## Interface
- XLEN, 32, datapath width; only 32 is supported.
- clk_i  in  1  core clock, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- stall_i  in  1  hold the current ID/EX contents
- flush_i  in  1  replace the next ID/EX contents with a bubble
- valid_i  in  1  decode slot holds a real instruction
- ctrl_i  in  id_ctrl_t  decoded control: alu_op[3:0], src_a_sel (0 = rs1, 1 = pc), src_b_sel (0 = rs2, 1 = imm), reg_write, mem_read, mem_write, uses_rs1, uses_rs2
- pc_i  in  32  instruction PC
- rs1_addr_i / rs2_addr_i  in  5 each  source register indices
- rd_addr_i  in  5  destination register index
- rs1_data_i / rs2_data_i  in  32 each  register file read data
- imm_i  in  32  sign-extended immediate
- exmem_wen_i, exmem_rd_i, exmem_data_i  in  1/5/32  EX/MEM writeback candidate (ALU result)
- memwb_wen_i, memwb_rd_i, memwb_data_i  in  1/5/32  MEM/WB writeback value
- operand_a_o / operand_b_o  out  32 each  to ALU operand_a_i/operand_b_i
- alu_op_o  out  4  to ALU alu_op_i
- valid_o  out  1  EX slot valid
- ctrl_o  out  id_ctrl_t  registered control, forwarded to EX/MEM
- pc_o  out  32  registered PC
- rd_addr_o  out  5  registered destination
- store_data_o  out  32  forwarded rs2 value for stores
- load_use_o  out  1  load-use hazard request to hazard unit
## Operation
- Register update priority: rst_i > flush_i > stall_i > load. Load copies all decode inputs. Flush writes a bubble: valid 0, all ctrl fields 0 (alu_op = `ALU_ADD`), pc/rd/rs/data/imm 0. Stall holds everything except the operand refresh rule.
- Forwarding per source (rs1_q, rs2_q): if rs_q == 0, use held data (x0 never forwarded). Else if exmem_wen_i && exmem_rd_i == rs_q, use exmem_data_i. Else if memwb_wen_i && memwb_rd_i == rs_q, use memwb_data_i. Else use held data. EX/MEM always wins over MEM/WB.
- Operand refresh: while stall_i && !flush_i, each held rs data register loads its forwarded value every cycle. A producer that retires during a multi-cycle stall is then not lost.
- operand_a_o = src_a_sel ? pc_q : fwd_rs1. operand_b_o = src_b_sel ? imm_q : fwd_rs2. store_data_o = fwd_rs2. alu_op_o = ctrl_q.alu_op.
- When valid_o = 0, operands still follow the rules above. The bubble guarantees zero operands and ADD.
- load_use_o = valid_q && ctrl_q.mem_read && rd_q != 0 && ((valid_i && ctrl_i.uses_rs1 && rs1_addr_i == rd_q) || (valid_i && ctrl_i.uses_rs2 && rs2_addr_i == rd_q)). Combinational. The hazard unit answers with stall of IF/ID plus flush of this stage.
## Timing
- Reset value of every registered output and of load_use_o is 0. alu_op_o resets to `ALU_ADD`.
- Latency: decode inputs appear on outputs one cycle after the capturing edge. Forwarding and operand selection are combinational within the EX cycle. The path is forward-mux → source-mux → ALU, with no extra register.
- flush_i and stall_i asserted together: flush wins, bubble inserted.
- Asynchronous reset mid-stall clears immediately. The first edge after deassertion loads normally.
## Structure
- Shared package core_pkg holds id_ctrl_t, the `ALU_*` opcode constants, and the SRC_A_RS1/PC and SRC_B_RS2/IMM encodings.
- Sub-module fwd_unit is instantiated twice, once per source. Inputs: rs index, held data, both writeback ports. Output: forwarded data.
## Test plan
- Reset, then load `add x3,x1,x2` with rs1_data=5, rs2_data=7 → next cycle operand_a_o=5, operand_b_o=7, alu_op_o=`ALU_ADD`, valid_o=1.
- EX/MEM and MEM/WB both targeting x1 with values 0xAAAA/0xBBBB → operand_a_o=0xAAAA. Drop exmem_wen_i → 0xBBBB.
- Held rs1=x0, memwb_rd_i=0, memwb_wen_i=1, data 0xFFFF → operand_a_o stays 0.
- Held `lw x5`, decode presents `add x6,x5,x1` with uses_rs1=1 → load_use_o=1. Same with rd=x0 → 0.
- Stall 3 cycles, with MEM/WB writing x2=0x1234 only in cycle 1 → operand_b_o=0x1234 in cycles 2 and 3 and after release.
- flush_i and stall_i both high on an edge → valid_o=0, ctrl_o all 0, operands 0. src_b_sel=1, imm=−4, rs1=10 → operand_b_o=0xFFFFFFFC.
